// File: rtl/port_bus_master.sv
// Purpose: port-bus initiator; turns a valid/ready read/write command stream into
//          PicoBlaze-style port_id/out_port/write_strobe/read_strobe cycles.
// Latency: write 4 cycles accept-to-ready; read 3+READ_LATENCY cycles accept-to-rsp_valid.
// Backpressure: one transaction in flight; cmd_ready low while busy, held RESP stalls commands.
// Ports: cmd_* valid/ready command in; rsp_* valid/ready read data out; busy = state != IDLE;
//        port_id/out_port/write_strobe/read_strobe drive the bus; in_port is the bus read mux.
module port_bus_master #(
    parameter int unsigned READ_LATENCY = 1,      // 1..15 cycles from read_strobe to capture
    parameter logic [7:0]  IDLE_ADDR    = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    output logic       write_strobe,
    output logic       read_strobe,
    input  logic [7:0] in_port
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WSTROBE,
        WHOLD,
        RSTROBE,
        RWAIT,
        RESP
    } state_t;

    // RWAIT lasts cnt+1 cycles, so loading LATENCY-1 gives exactly READ_LATENCY cycles.
    localparam logic [3:0] RWAIT_LOAD = 4'(READ_LATENCY - 1);

    state_t     state;
    state_t     state_nxt;
    logic       is_write;
    logic [3:0] cnt;
    logic [7:0] port_id_q;
    logic [7:0] out_port_q;
    logic [7:0] rsp_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address/data are latched straight into the bus registers, so the bus
    // outputs never see cmd_* combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_write   <= 1'b0;
            cnt        <= 4'd0;
            port_id_q  <= IDLE_ADDR;
            out_port_q <= 8'h00;
            rsp_data_q <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        is_write  <= cmd_write;
                        port_id_q <= cmd_addr;
                        // reads leave out_port at its previous value
                        if (cmd_write) begin
                            out_port_q <= cmd_wdata;
                        end
                    end
                end
                RSTROBE: cnt <= RWAIT_LOAD;
                RWAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_data_q <= in_port;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = is_write ? WSTROBE : RSTROBE;
            WSTROBE: state_nxt = WHOLD;
            WHOLD:   state_nxt = IDLE;
            RSTROBE: state_nxt = RWAIT;
            RWAIT:   if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        rsp_valid    = 1'b0;
        busy         = 1'b1;
        cmd_ready    = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                // held low during reset so nothing is offered before the FSM is known-good
                cmd_ready = ~rst;
            end
            WSTROBE: write_strobe = 1'b1;
            RSTROBE: read_strobe  = 1'b1;
            RESP:    rsp_valid    = 1'b1;
            default: ;
        endcase
    end

    assign port_id  = port_id_q;
    assign out_port = out_port_q;
    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_port_bus_master.sv
// Purpose: directed bench for port_bus_master (READ_LATENCY=1 and =3 instances).
// Latency: n/a (testbench).
// Backpressure: exercises rsp_ready stalls and held cmd_valid.
module tb_port_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // instance 1: READ_LATENCY=1, IDLE_ADDR=00, behind a registered input mux
    logic       cv1, cr1, cw1, rv1, rr1, busy1, ws1, rs1;
    logic [7:0] ca1, cd1, rd1, pid1, op1, in1;
    // instance 3: READ_LATENCY=3, IDLE_ADDR=5A, in_port driven directly
    logic       cv3, cr3, cw3, rv3, rr3, busy3, ws3, rs3;
    logic [7:0] ca3, cd3, rd3, pid3, op3, in3;

    logic [4:0] obs1, obs3;
    assign obs1 = {ws1, rs1, busy1, cr1, rv1};
    assign obs3 = {ws3, rs3, busy3, cr3, rv3};

    int tests  = 0;
    int failed = 0;

    port_bus_master #(.READ_LATENCY(1), .IDLE_ADDR(8'h00)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cv1), .cmd_ready(cr1), .cmd_write(cw1), .cmd_addr(ca1), .cmd_wdata(cd1),
        .rsp_valid(rv1), .rsp_ready(rr1), .rsp_data(rd1), .busy(busy1),
        .port_id(pid1), .out_port(op1), .write_strobe(ws1), .read_strobe(rs1), .in_port(in1)
    );

    port_bus_master #(.READ_LATENCY(3), .IDLE_ADDR(8'h5A)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(cv3), .cmd_ready(cr3), .cmd_write(cw3), .cmd_addr(ca3), .cmd_wdata(cd3),
        .rsp_valid(rv3), .rsp_ready(rr3), .rsp_data(rd3), .busy(busy3),
        .port_id(pid3), .out_port(op3), .write_strobe(ws3), .read_strobe(rs3), .in_port(in3)
    );

    // Peripheral model: output ports captured on write_strobe, registered input mux.
    // Port 00 reads in0_val; every other port reads back what was last written to it.
    logic [7:0] oregs [256];
    logic [7:0] in0_val;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) oregs[i] <= 8'h00;
        end else if (ws1) begin
            oregs[pid1] <= op1;
        end
        in1 <= (pid1 == 8'h00) ? in0_val : oregs[pid1];
    end

    // Strobe-rule monitor: never both, never two cycles in a row.
    int   strobe_viol = 0;
    logic prev1 = 1'b0;
    logic prev3 = 1'b0;
    always @(negedge clk) begin
        if ((ws1 && rs1) || ((ws1 || rs1) && prev1) || (ws3 && rs3) || ((ws3 || rs3) && prev3)) begin
            strobe_viol++;
        end
        prev1 = (ws1 === 1'b1) || (rs1 === 1'b1);
        prev3 = (ws3 === 1'b1) || (rs3 === 1'b1);
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({obs1, rd1, pid1, op1} !== {5'b00000, 8'h00, 8'h00, 8'h00}) begin
            failed++;
            $display("FAIL reset_state_1: got %b %h %h %h expected 00000 00 00 00", obs1, rd1, pid1, op1);
        end
        tests++;
        if ({obs3, rd3, pid3, op3} !== {5'b00000, 8'h00, 8'h5A, 8'h00}) begin
            failed++;
            $display("FAIL reset_state_3: got %b %h %h %h expected 00000 00 5a 00", obs3, rd3, pid3, op3);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({obs1, obs3} !== {5'b00010, 5'b00010}) begin
            failed++;
            $display("FAIL reset_release_ready: got %b %b expected 00010 00010", obs1, obs3);
        end
    endtask

    task automatic test_write();
        logic [4:0] exp;
        @(posedge clk); #1;
        cv1 = 1'b1; cw1 = 1'b1; ca1 = 8'h05; cd1 = 8'hA5;
        @(posedge clk); #1;
        // scramble the command inputs to prove the master latched them
        cv1 = 1'b0; cw1 = 1'b0; ca1 = 8'h00; cd1 = 8'h00;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            exp = (c == 2) ? 5'b10100 : (c == 4) ? 5'b00010 : 5'b00100;
            tests++;
            if ({obs1, pid1, op1} !== {exp, 8'h05, 8'hA5}) begin
                failed++;
                $display("FAIL write_cycle%0d: got %b %h %h expected %b 05 a5", c, obs1, pid1, op1, exp);
            end
        end
        tests++;
        if (oregs[5] !== 8'hA5) begin
            failed++;
            $display("FAIL write_port05: got %h expected a5", oregs[5]);
        end
    endtask

    task automatic test_read_lat1();
        logic [4:0] exp;
        in0_val = 8'h3C;
        rr1 = 1'b0;
        @(posedge clk); #1;
        cv1 = 1'b1; cw1 = 1'b0; ca1 = 8'h00; cd1 = 8'h00;
        @(posedge clk); #1;
        cv1 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 6) rr1 = 1'b1;
            if (c == 7) rr1 = 1'b0;
            @(negedge clk);
            exp = (c == 2) ? 5'b01100 : (c >= 4 && c <= 6) ? 5'b00101 : (c == 7) ? 5'b00010 : 5'b00100;
            tests++;
            if (obs1 !== exp) begin
                failed++;
                $display("FAIL read1_cycle%0d: got %b expected %b", c, obs1, exp);
            end
            if (c >= 4 && c <= 6) begin
                tests++;
                if (rd1 !== 8'h3C) begin
                    failed++;
                    $display("FAIL read1_data_c%0d: got %h expected 3c", c, rd1);
                end
            end
            if (c < 7) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_read_lat3();
        logic [4:0] exp;
        in3 = 8'h11;
        rr3 = 1'b1;
        @(posedge clk); #1;
        cv3 = 1'b1; cw3 = 1'b0; ca3 = 8'h33; cd3 = 8'h00;
        @(posedge clk); #1;
        cv3 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 5) in3 = 8'h22;
            @(negedge clk);
            exp = (c == 2) ? 5'b01100 : (c == 6) ? 5'b00101 : (c == 7) ? 5'b00010 : 5'b00100;
            tests++;
            if (obs3 !== exp) begin
                failed++;
                $display("FAIL read3_cycle%0d: got %b expected %b", c, obs3, exp);
            end
            if (c == 6) begin
                tests++;
                if ({rd3, pid3} !== {8'h22, 8'h33}) begin
                    failed++;
                    $display("FAIL read3_data: got %h %h expected 22 33", rd3, pid3);
                end
            end
            if (c < 7) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic drive_b2b(input int idx);
        cv1 = 1'b1;
        case (idx)
            0:       begin cw1 = 1'b1; ca1 = 8'h01; cd1 = 8'h55; end
            1:       begin cw1 = 1'b0; ca1 = 8'h01; cd1 = 8'h00; end
            default: begin cw1 = 1'b1; ca1 = 8'h02; cd1 = 8'hAA; end
        endcase
    endtask

    task automatic test_back_to_back();
        int         idx  = 0;
        int         nrsp = 0;
        int         acc [3];
        logic       hs;
        logic [7:0] got = 8'h00;
        for (int i = 0; i < 3; i++) acc[i] = -1;
        rr1 = 1'b1;
        @(posedge clk); #1;
        drive_b2b(0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            hs = cv1 && cr1;
            if (rv1 && rr1) begin
                nrsp++;
                got = rd1;
            end
            @(posedge clk); #1;
            if (hs && idx < 3) begin
                acc[idx] = cyc;
                idx++;
                if (idx < 3) drive_b2b(idx);
                else cv1 = 1'b0;
            end
        end
        cv1 = 1'b0;
        tests++;
        if (acc[0] != 0 || acc[1] != 4 || acc[2] != 9) begin
            failed++;
            $display("FAIL b2b_accept_edges: got %0d %0d %0d expected 0 4 9", acc[0], acc[1], acc[2]);
        end
        tests++;
        if (nrsp != 1 || got !== 8'h55) begin
            failed++;
            $display("FAIL b2b_response: got %0d responses data %h expected 1 responses data 55", nrsp, got);
        end
        tests++;
        if (oregs[2] !== 8'hAA) begin
            failed++;
            $display("FAIL b2b_port02: got %h expected aa", oregs[2]);
        end
    endtask

    task automatic test_boundary();
        logic [4:0] exp_tab [10];
        exp_tab = '{5'b00010, 5'b00100, 5'b10100, 5'b00100, 5'b00010,
                    5'b00100, 5'b01100, 5'b00100, 5'b00101, 5'b00010};
        rr1 = 1'b1;
        @(posedge clk); #1;
        cv1 = 1'b1; cw1 = 1'b1; ca1 = 8'hFF; cd1 = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests++;
            if (obs1 !== exp_tab[c]) begin
                failed++;
                $display("FAIL boundary_cycle%0d: got %b expected %b", c, obs1, exp_tab[c]);
            end
            if (c == 8) begin
                tests++;
                if (rd1 !== 8'hFF) begin
                    failed++;
                    $display("FAIL boundary_rdata: got %h expected ff", rd1);
                end
            end
            if (c == 9) begin
                tests++;
                if ({pid1, op1} !== {8'hFF, 8'hFF}) begin
                    failed++;
                    $display("FAIL boundary_bus_hold: got %h %h expected ff ff", pid1, op1);
                end
            end
            @(posedge clk); #1;
            if (c == 0) cv1 = 1'b0;
            if (c == 3) begin cv1 = 1'b1; cw1 = 1'b0; ca1 = 8'hFF; cd1 = 8'h00; end
            if (c == 4) cv1 = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        // reset while write_strobe is high
        @(posedge clk); #1;
        cv1 = 1'b1; cw1 = 1'b1; ca1 = 8'h07; cd1 = 8'hC3;
        @(posedge clk); #1;
        cv1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (obs1 !== 5'b10100) begin
            failed++;
            $display("FAIL rstw_pre: got %b expected 10100", obs1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({obs1, pid1, op1} !== {5'b00000, 8'h00, 8'h00}) begin
            failed++;
            $display("FAIL rstw_edge: got %b %h %h expected 00000 00 00", obs1, pid1, op1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (obs1 !== 5'b00010) begin
            failed++;
            $display("FAIL rstw_release: got %b expected 00010", obs1);
        end
        // reset while a response is held
        in0_val = 8'h3C;
        rr1 = 1'b0;
        @(posedge clk); #1;
        cv1 = 1'b1; cw1 = 1'b0; ca1 = 8'h00;
        @(posedge clk); #1;
        cv1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({obs1, rd1} !== {5'b00101, 8'h3C}) begin
            failed++;
            $display("FAIL rstr_pre: got %b %h expected 00101 3c", obs1, rd1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rr1 = 1'b1;
        @(negedge clk);
        tests++;
        if ({obs1, rd1, pid1} !== {5'b00010, 8'h00, 8'h00}) begin
            failed++;
            $display("FAIL rstr_release: got %b %h %h expected 00010 00 00", obs1, rd1, pid1);
        end
        repeat (3) begin
            @(negedge clk);
            if (rv1 !== 1'b0) stale++;
        end
        tests++;
        if (stale != 0) begin
            failed++;
            $display("FAIL rstr_stale_rsp: got %0d cycles of rsp_valid expected 0", stale);
        end
    endtask

    task automatic test_strobe_rules();
        tests++;
        if (strobe_viol != 0) begin
            failed++;
            $display("FAIL strobe_rules: got %0d violations expected 0", strobe_viol);
        end
    endtask

    initial begin
        rst = 1'b1;
        cv1 = 1'b0; cw1 = 1'b0; ca1 = 8'h00; cd1 = 8'h00; rr1 = 1'b0;
        cv3 = 1'b0; cw3 = 1'b0; ca3 = 8'h00; cd3 = 8'h00; rr3 = 1'b1;
        in3 = 8'h00;
        in0_val = 8'h00;
        test_reset();
        test_write();
        test_read_lat1();
        test_read_lat3();
        test_back_to_back();
        test_boundary();
        test_reset_mid();
        test_strobe_rules();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
